// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-write, NRD-read register file with write bypass and sequenced clear.
// Define ZERO_REG_EN to hardwire register 0 to zero.
module regfile_mp #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int NREG  = 16,
  parameter int NRD   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wen0,
  input  logic [ASIZE-1:0]       waddr0,
  input  logic [DSIZE-1:0]       wdata0,
  input  logic                   wen1,
  input  logic [ASIZE-1:0]       waddr1,
  input  logic [DSIZE-1:0]       wdata1,
  input  logic [NRD*ASIZE-1:0]   raddr,
  output logic [NRD*DSIZE-1:0]   rdata,
  output logic                   ready
);

  localparam logic [ASIZE:0] NREG_W = (ASIZE+1)'(NREG);
  localparam logic [ASIZE:0] LAST   = (ASIZE+1)'(NREG - 1);
`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [ASIZE:0]   clr_cnt, clr_cnt_nxt;
  logic             ready_nxt;
  logic [DSIZE-1:0] mem [NREG];

  function automatic logic writable(input logic [ASIZE-1:0] a);
    return ({1'b0, a} < NREG_W) && !(ZERO_REG && (a == '0));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      ready   <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    ready_nxt   = ready;
    case (state)
      INIT: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end
      end
      RUN:     ;
      default: state_nxt = INIT;
    endcase
  end

  logic we0, we1;
  assign we1 = (state == RUN) && wen1 && writable(waddr1);
  // Port 1 wins a same-address collision, so port 0 is dropped outright.
  assign we0 = (state == RUN) && wen0 && writable(waddr0) && !(we1 && (waddr1 == waddr0));

  // Storage has no reset; it is only cleared by the INIT sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[clr_cnt[ASIZE-1:0]] <= '0;
      end else begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ASIZE-1:0] a;
    logic [DSIZE-1:0] lane;
    assign a = raddr[k*ASIZE +: ASIZE];

    always_comb begin
      lane = '0;
      if ((state == RUN) && writable(a)) begin
        if (wen1 && (waddr1 == a))      lane = wdata1;
        else if (wen0 && (waddr0 == a)) lane = wdata0;
        else                            lane = mem[a];
      end
    end

    assign rdata[k*DSIZE +: DSIZE] = lane;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen0, wen1;
  logic [3:0]  waddr0, waddr1;
  logic [15:0] wdata0, wdata1;
  logic [7:0]  raddr;
  logic [31:0] rdata;
  logic        ready;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp #(.DSIZE(16), .ASIZE(4), .NREG(16), .NRD(2)) dut (
    .clk(clk), .rst(rst),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    wen0 = 1'b0; wen1 = 1'b0;
    waddr0 = '0; waddr1 = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic release_and_clear(input string tag);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 16) check_val({tag, "_ready_lo"}, {31'd0, ready}, 32'd0);
      else        check_val({tag, "_ready_hi"}, {31'd0, ready}, 32'd1);
    end
  endtask

  logic [15:0] zexp;

  initial begin
    rst = 1'b1;
    idle_writes();
    raddr = '0;
    tick();
    tick();
    check_val("reset_ready", {31'd0, ready}, 32'd0);

    // Clear sequence with a write attempt to address 3 held throughout INIT.
    wen0 = 1'b1; waddr0 = 4'd3; wdata0 = 16'h00AA;
    raddr = {4'd3, 4'd3};
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      check_val("init_rdata", rdata, 32'd0);
      @(posedge clk);
      #1;
      if (i < 16) check_val("clr_ready_lo", {31'd0, ready}, 32'd0);
      else        check_val("clr_ready_hi", {31'd0, ready}, 32'd1);
    end
    idle_writes();
    for (int i = 0; i < 16; i++) begin
      raddr = {4'(15 - i), 4'(i)};
      #1;
      check_val("cleared_read", rdata, 32'd0);
    end

    // Dual write with same-cycle bypass, then storage read-back.
    wen0 = 1'b1; waddr0 = 4'd5; wdata0 = 16'h1234;
    wen1 = 1'b1; waddr1 = 4'd6; wdata1 = 16'h5678;
    raddr = {4'd6, 4'd5};
    #1;
    check_val("dual_bypass", rdata, 32'h5678_1234);
    tick();
    idle_writes();
    #1;
    check_val("dual_stored", rdata, 32'h5678_1234);

    // Port 0 bypass overrides stored value; lane 1 still sees storage.
    wen0 = 1'b1; waddr0 = 4'd5; wdata0 = 16'hAAAA;
    #1;
    check_val("p0_bypass", rdata, 32'h5678_AAAA);
    tick();
    idle_writes();
    #1;
    check_val("p0_stored", rdata, 32'h5678_AAAA);

    // Collision: port 1 wins for both bypass and storage.
    wen0 = 1'b1; waddr0 = 4'd7; wdata0 = 16'h1111;
    wen1 = 1'b1; waddr1 = 4'd7; wdata1 = 16'h2222;
    raddr = {4'd7, 4'd7};
    #1;
    check_val("coll_bypass", rdata, 32'h2222_2222);
    tick();
    idle_writes();
    #1;
    check_val("coll_stored", rdata, 32'h2222_2222);

    // Register 0 write, same cycle and next cycle.
`ifdef ZERO_REG_EN
    zexp = 16'h0000;
`else
    zexp = 16'hBEEF;
`endif
    wen1 = 1'b1; waddr1 = 4'd0; wdata1 = 16'hBEEF;
    raddr = {4'd7, 4'd0};
    #1;
    check_val("zero_bypass", rdata, {16'h2222, zexp});
    tick();
    idle_writes();
    #1;
    check_val("zero_stored", rdata, {16'h2222, zexp});

    // Reset mid-operation, then again mid-INIT.
    wen0 = 1'b1; waddr0 = 4'd4; wdata0 = 16'h00FF;
    tick();
    idle_writes();
    raddr = {4'd5, 4'd4};
    #1;
    check_val("mem4_written", rdata, 32'hAAAA_00FF);
    rst = 1'b1;
    tick();
    check_val("run_rst_ready", {31'd0, ready}, 32'd0);
    check_val("run_rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("part_init_ready", {31'd0, ready}, 32'd0);
    end
    rst = 1'b1;
    tick();
    check_val("reinit_ready", {31'd0, ready}, 32'd0);
    release_and_clear("reclr");
    #1;
    check_val("mem4_cleared", rdata, 32'd0);
    raddr = {4'd7, 4'd6};
    #1;
    check_val("mem67_cleared", rdata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
